// File: rtl/wb_regfile_if.sv
// Writeback/register-file bundle: MEM/WB writeback fields, decode read ports and status outputs.
// The master drives the pipeline and read indices, and the slave is the register file.
interface wb_regfile_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              memtoreg;
    logic              regwrite;
    logic [DATA_W-1:0] wb_aluout;
    logic [DATA_W-1:0] wb_memdata;
    logic [ADDR_W-1:0] wb_dst;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [DATA_W-1:0] wb_data;
    logic              wb_commit;
    logic [CNT_W-1:0]  retired_cnt;

    modport master (
        output memtoreg, regwrite, wb_aluout, wb_memdata, wb_dst, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_data, wb_commit, retired_cnt
    );

    modport slave (
        input  memtoreg, regwrite, wb_aluout, wb_memdata, wb_dst, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_data, wb_commit, retired_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage plus 2**ADDR_W x DATA_W register file: 1-cycle write, 0-cycle reads with bypass.
// R0 reads as zero and ignores writes. A synchronous reset clears the array and the retired counter.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    wb_regfile_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_regs [NREG];
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_commit;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    assign w_wb_data = bus.memtoreg ? bus.wb_memdata : bus.wb_aluout;
    // Reset suppresses commit, which also disables the bypass path during reset.
    assign w_commit  = bus.regwrite & (bus.wb_dst != '0) & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_cnt <= '0;
        end else if (w_commit) begin
            r_regs[bus.wb_dst] <= w_wb_data;
            r_cnt              <= r_cnt + CNT_ONE;
        end
    end

    always_comb begin
        w_rd_a = r_regs[bus.rd_addr_a];
        if (bus.rd_addr_a == '0) begin
            w_rd_a = '0;
        end else if (w_commit && (bus.rd_addr_a == bus.wb_dst)) begin
            w_rd_a = w_wb_data;
        end
    end

    always_comb begin
        w_rd_b = r_regs[bus.rd_addr_b];
        if (bus.rd_addr_b == '0) begin
            w_rd_b = '0;
        end else if (w_commit && (bus.rd_addr_b == bus.wb_dst)) begin
            w_rd_b = w_wb_data;
        end
    end

    assign bus.rd_data_a   = w_rd_a;
    assign bus.rd_data_b   = w_rd_b;
    assign bus.wb_data     = w_wb_data;
    assign bus.wb_commit   = w_commit;
    assign bus.retired_cnt = r_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed and random bench for wb_regfile with a 4-bit retired counter, so wrap is reachable.
// An array-and-integer model is checked every negedge; literal checks pin the directed cases.
module tb_wb_regfile;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference state: the register contents and the total number of commits.
    int unsigned m_regs [16];
    int unsigned m_commits = 0;

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned m_sel();
        return bus.memtoreg ? int'(bus.wb_memdata) : int'(bus.wb_aluout);
    endfunction

    function automatic bit m_commit();
        return bus.regwrite && (bus.wb_dst != 0) && !rst;
    endfunction

    function automatic int unsigned m_read(input int unsigned idx);
        if (idx == 0) return 0;
        if (m_commit() && idx == int'(bus.wb_dst)) return m_sel();
        return m_regs[idx];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 0;
            m_commits = 0;
        end else if (m_commit()) begin
            m_regs[bus.wb_dst] = m_sel();
            m_commits++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_wb_data", 32'(bus.wb_data), 32'(m_sel()));
            chk("m_commit", 32'(bus.wb_commit), 32'(m_commit()));
            chk("m_rd_a", 32'(bus.rd_data_a), 32'(m_read(bus.rd_addr_a)));
            chk("m_rd_b", 32'(bus.rd_data_b), 32'(m_read(bus.rd_addr_b)));
            chk("m_cnt", 32'(bus.retired_cnt), 32'(m_commits % 16));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input bit rw, input bit m2r, input logic [15:0] alu,
                      input logic [15:0] mem, input logic [3:0] dst);
        bus.regwrite   = rw;
        bus.memtoreg   = m2r;
        bus.wb_aluout  = alu;
        bus.wb_memdata = mem;
        bus.wb_dst     = dst;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wb(1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        bus.rd_addr_a = 4'd3;
        bus.rd_addr_b = 4'd0;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        #2;
        chk("rst_rd_a", 32'(bus.rd_data_a), 32'h0);
        chk("rst_cnt", 32'(bus.retired_cnt), 32'h0);

        // R3 = 0x1234, then a reset pulse clears it.
        wb(1'b1, 1'b0, 16'h1234, 16'h0, 4'd3);
        tick();
        wb(1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        #2;
        chk("r3_written", 32'(bus.rd_data_a), 32'h1234);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("r3_after_rst", 32'(bus.rd_data_a), 32'h0);
        chk("cnt_after_rst", 32'(bus.retired_cnt), 32'h0);

        // ALU result, then load data, into R5.
        bus.rd_addr_a = 4'd5;
        wb(1'b1, 1'b0, 16'h00AA, 16'h7777, 4'd5);
        #2;
        chk("mux_alu", 32'(bus.wb_data), 32'h00AA);
        tick();
        wb(1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        #2;
        chk("r5_alu", 32'(bus.rd_data_a), 32'h00AA);
        wb(1'b1, 1'b1, 16'h3333, 16'hBEEF, 4'd5);
        #2;
        chk("mux_mem", 32'(bus.wb_data), 32'hBEEF);
        tick();
        wb(1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        #2;
        chk("r5_mem", 32'(bus.rd_data_a), 32'hBEEF);
        chk("cnt_two", 32'(bus.retired_cnt), 32'h2);

        // Same-cycle bypass on both ports.
        bus.rd_addr_a = 4'd7;
        bus.rd_addr_b = 4'd7;
        wb(1'b1, 1'b0, 16'h5A5A, 16'h0, 4'd7);
        #2;
        chk("byp_a", 32'(bus.rd_data_a), 32'h5A5A);
        chk("byp_b", 32'(bus.rd_data_b), 32'h5A5A);
        chk("byp_commit", 32'(bus.wb_commit), 32'h1);
        tick();
        wb(1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        #2;
        chk("r7_held", 32'(bus.rd_data_a), 32'h5A5A);

        // A write to R0 is dropped.
        bus.rd_addr_a = 4'd0;
        bus.rd_addr_b = 4'd0;
        wb(1'b1, 1'b0, 16'hFFFF, 16'h0, 4'd0);
        #2;
        chk("r0_commit", 32'(bus.wb_commit), 32'h0);
        chk("r0_read", 32'(bus.rd_data_a), 32'h0);
        tick();
        wb(1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        #2;
        chk("r0_cnt", 32'(bus.retired_cnt), 32'h3);

        // Reset and a write on the same edge: reset wins, and there is no bypass during reset.
        bus.rd_addr_a = 4'd2;
        bus.rd_addr_b = 4'd7;
        wb(1'b1, 1'b0, 16'h1111, 16'h0, 4'd2);
        rst = 1'b1;
        #2;
        chk("col_commit", 32'(bus.wb_commit), 32'h0);
        chk("col_nobyp", 32'(bus.rd_data_a), 32'h0);
        chk("col_array", 32'(bus.rd_data_b), 32'h5A5A);
        tick();
        rst = 1'b0;
        wb(1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        #2;
        chk("col_r2", 32'(bus.rd_data_a), 32'h0);
        chk("col_cnt", 32'(bus.retired_cnt), 32'h0);

        // Seventeen commits wrap the 4-bit counter to 1.
        bus.rd_addr_a = 4'd1;
        for (int i = 0; i < 17; i++) begin
            wb(1'b1, 1'b0, 16'(i), 16'h0, 4'd1);
            tick();
        end
        wb(1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        #2;
        chk("wrap_cnt", 32'(bus.retired_cnt), 32'h1);
        chk("wrap_r1", 32'(bus.rd_data_a), 32'h10);

        // Random traffic, checked by the model on every negedge.
        for (int i = 0; i < 16; i++) begin
            wb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom()),
               16'($urandom()), 4'($urandom_range(0, 15)));
            bus.rd_addr_a = 4'($urandom_range(0, 15));
            bus.rd_addr_b = 4'($urandom_range(0, 15));
            tick();
        end
        wb(1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
